// File: rtl/chip_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chip_buf_if : sample-in / packet-out bundle for chip_buf           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface chip_buf_if;
  logic [15:0] d1_data;
  logic        d1_vld;
  logic [6:0]  sel_path;
  logic        buf_rdy;
  logic [15:0] tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        tx_sof;
  logic        tx_eof;

  modport master (
    output d1_data, d1_vld, sel_path, tx_rdy,
    input  buf_rdy, tx_data, tx_vld, tx_sof, tx_eof
  );

  modport slave (
    input  d1_data, d1_vld, sel_path, tx_rdy,
    output buf_rdy, tx_data, tx_vld, tx_sof, tx_eof
  );
endinterface
`default_nettype wire

// File: rtl/chip_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chip_buf : captures one chip into RAM and streams it as a frame    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module chip_buf #(
  parameter int          CHIP_LEN = 4000,
  parameter int          AW       = 12,
  parameter int          GAP_TO   = 256,
  parameter logic [15:0] SYNC     = 16'hA55A
) (
  input  wire logic        clk_sys,
  input  wire logic        rst,
  chip_buf_if.slave        bus,
  output logic [15:0]      stat_chip_cnt,
  output logic [15:0]      stat_drop_cnt
);

  localparam int             IW         = $clog2(GAP_TO) + 1;
  localparam logic [AW-1:0]  c_last     = AW'(CHIP_LEN - 1);
  localparam logic [AW-1:0]  c_one      = AW'(1);
  localparam logic [IW-1:0]  c_gap_last = IW'(GAP_TO - 1);
  localparam logic [IW-1:0]  c_idle_one = IW'(1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_LAST = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, r_len, r_nidx, w_raddr;
  logic [IW-1:0]   r_idle;
  logic [6:0]      r_path;
  logic [1:0]      r_hidx;
  logic [15:0]     r_mem [0:(1<<AW)-1];
  logic [15:0]     r_rd_data;
  logic [15:0]     r_tx_data, w_tx_word;
  logic            r_tx_vld, r_tx_sof, r_tx_eof;
  logic            w_tx_sof, w_tx_eof;
  logic            w_buf_rdy, w_we, w_close, w_load, w_done, w_slot;
  logic [15:0]     r_chip_cnt, r_drop_cnt;

  assign w_buf_rdy = (r_state == S_FILL);
  assign w_slot    = !r_tx_vld || bus.tx_rdy;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_close     = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_tx_word   = 16'h0000;
    w_tx_sof    = 1'b0;
    w_tx_eof    = 1'b0;
    w_raddr     = r_nidx;
    case (r_state)
      S_FILL: begin
        if (bus.d1_vld) begin
          w_we = 1'b1;
          if (r_cnt == c_last) begin
            w_close     = 1'b1;
            w_state_nxt = S_HDR;
          end
        end else if ((r_cnt != '0) && (r_idle == c_gap_last)) begin
          w_close     = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (w_slot) begin
          w_load = 1'b1;
          case (r_hidx)
            2'd0: begin
              w_tx_word = SYNC;
              w_tx_sof  = 1'b1;
            end
            2'd1:    w_tx_word = {9'h000, r_path};
            default: begin
              w_tx_word   = 16'(r_len);
              w_state_nxt = S_DATA;
            end
          endcase
        end
      end
      S_DATA: begin
        // Read address runs one ahead of the word being loaded so the
        // RAM's registered output always holds the next word to send.
        if (w_slot) begin
          w_load    = 1'b1;
          w_tx_word = r_rd_data;
          w_raddr   = r_nidx + c_one;
          if ((r_nidx + c_one) == r_len) begin
            w_tx_eof    = 1'b1;
            w_state_nxt = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (bus.tx_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (w_we) r_mem[r_cnt] <= bus.d1_data;
    r_rd_data <= r_mem[w_raddr];
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_len  <= '0;
      r_path <= '0;
      r_idle <= '0;
      r_hidx <= '0;
      r_nidx <= '0;
    end else begin
      if (w_done)    r_cnt <= '0;
      else if (w_we) r_cnt <= r_cnt + c_one;

      if (w_we && (r_cnt == '0)) r_path <= bus.sel_path;

      if (w_close) r_len <= w_we ? (r_cnt + c_one) : r_cnt;

      if ((r_state != S_FILL) || bus.d1_vld || w_close) r_idle <= '0;
      else if (r_cnt != '0)                                r_idle <= r_idle + c_idle_one;

      if (r_state != S_HDR) r_hidx <= '0;
      else if (w_load)      r_hidx <= r_hidx + 2'd1;

      if (r_state != S_DATA) r_nidx <= '0;
      else if (w_load)       r_nidx <= r_nidx + c_one;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_tx_data <= 16'h0000;
      r_tx_vld  <= 1'b0;
      r_tx_sof  <= 1'b0;
      r_tx_eof  <= 1'b0;
    end else if (w_load) begin
      r_tx_data <= w_tx_word;
      r_tx_vld  <= 1'b1;
      r_tx_sof  <= w_tx_sof;
      r_tx_eof  <= w_tx_eof;
    end else if (bus.tx_rdy) begin
      r_tx_vld  <= 1'b0;
      r_tx_sof  <= 1'b0;
      r_tx_eof  <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_chip_cnt <= 16'h0000;
      r_drop_cnt <= 16'h0000;
    end else begin
      if (w_done) r_chip_cnt <= r_chip_cnt + 16'h0001;
      if (bus.d1_vld && !w_buf_rdy && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'h0001;
    end
  end

  assign bus.buf_rdy    = w_buf_rdy;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_vld     = r_tx_vld;
  assign bus.tx_sof     = r_tx_sof;
  assign bus.tx_eof     = r_tx_eof;
  assign stat_chip_cnt  = r_chip_cnt;
  assign stat_drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_chip_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_chip_buf : randomized bench for chip_buf against a frame model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_chip_buf;
  localparam int          CL = 10;
  localparam int          GT = 8;
  localparam logic [15:0] SY = 16'hA55A;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  chip_buf_if bif();
  logic [15:0] stat_chip_cnt, stat_drop_cnt;

  chip_buf #(.CHIP_LEN(CL), .AW(4), .GAP_TO(GT), .SYNC(SY)) dut (
    .clk_sys       (clk),
    .rst           (rst),
    .bus           (bif.slave),
    .stat_chip_cnt (stat_chip_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  int n_vec = 0, n_err = 0, cyc = 0, hold_viol = 0;
  int exp_chip = 0, exp_drop = 0;
  logic [17:0] rx_q[$];
  int          rx_cyc[$];
  logic [17:0] exp_q[$];
  logic [15:0] smp[$];
  bit          stall_q = 1'b0;
  logic [17:0] stall_w = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every transferred word {data,sof,eof} and watches for held-word changes.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && (!bif.tx_vld || {bif.tx_data, bif.tx_sof, bif.tx_eof} !== stall_w))
        hold_viol++;
      stall_q = bif.tx_vld && !bif.tx_rdy;
      stall_w = {bif.tx_data, bif.tx_sof, bif.tx_eof};
      if (bif.tx_vld && bif.tx_rdy) begin
        rx_q.push_back({bif.tx_data, bif.tx_sof, bif.tx_eof});
        rx_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    bif.d1_vld = 1'b0;
    bif.tx_rdy = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_q();
    exp_chip  = 0;
    exp_drop  = 0;
    hold_viol = 0;
    step();
  endtask

  task automatic gen_samples(input int n);
    smp.delete();
    for (int i = 0; i < n; i++) smp.push_back(16'($urandom));
  endtask

  // Reference frame: sync, zero-extended path, length, then the samples.
  task automatic model_frame(input logic [6:0] path);
    exp_q.push_back({SY, 2'b10});
    exp_q.push_back({9'h000, path, 2'b00});
    exp_q.push_back({16'(smp.size()), 2'b00});
    for (int i = 0; i < smp.size(); i++)
      exp_q.push_back({smp[i], 1'b0, (i == smp.size() - 1)});
    exp_chip++;
  endtask

  task automatic push_chip(input logic [6:0] path, input bit mid_change);
    for (int i = 0; i < smp.size(); i++) begin
      bif.d1_data  = smp[i];
      bif.d1_vld   = 1'b1;
      bif.sel_path = (i == 0 || !mid_change) ? path : 7'($urandom);
      step();
    end
    bif.d1_vld = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 600 && rx_q.size() < n; k++) step();
    step();
  endtask

  task automatic test_reset();
    bif.d1_vld = 1'b0; bif.d1_data = '0; bif.sel_path = '0; bif.tx_rdy = 1'b1;
    #2 rst = 1'b1;
    #2;
    n_vec++;
    if ({bif.buf_rdy, bif.tx_vld, bif.tx_sof, bif.tx_eof} !== 4'b1000) begin
      n_err++; $display("FAIL reset_flags got=%b exp=1000", {bif.buf_rdy, bif.tx_vld, bif.tx_sof, bif.tx_eof});
    end
    n_vec++;
    if ({bif.tx_data, stat_chip_cnt, stat_drop_cnt} !== 48'h0) begin
      n_err++; $display("FAIL reset_values got=%h exp=0", {bif.tx_data, stat_chip_cnt, stat_drop_cnt});
    end
    step();
    rst = 1'b0;
    clear_q();
    repeat (3 * GT) step();
    n_vec++;
    if (bif.buf_rdy !== 1'b1 || rx_q.size() != 0) begin
      n_err++; $display("FAIL empty_no_timeout buf_rdy=%b words=%0d exp buf_rdy=1 words=0", bif.buf_rdy, rx_q.size());
    end
  endtask

  task automatic test_basic();
    int t_fall;
    clear_q();
    bif.tx_rdy = 1'b1;
    smp.delete();
    for (int i = 1; i <= CL; i++) smp.push_back(16'(i));
    model_frame(7'd3);
    push_chip(7'd3, 1'b0);
    t_fall = cyc;
    n_vec++;
    if (bif.buf_rdy !== 1'b0) begin
      n_err++; $display("FAIL basic_buf_rdy_fall got=%b exp=0", bif.buf_rdy);
    end
    wait_rx(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [17:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
    n_vec++;
    if (rx_cyc.size() < exp_q.size() || (rx_cyc[0] - t_fall) > 2) begin
      n_err++; $display("FAIL basic_sync_latency words=%0d lat=%0d exp<=2", rx_cyc.size(), rx_cyc.size() ? rx_cyc[0] - t_fall : -1);
    end else begin
      for (int i = 1; i < exp_q.size(); i++) begin
        n_vec++;
        if (rx_cyc[i] != rx_cyc[i-1] + 1) begin
          n_err++; $display("FAIL basic_b2b[%0d] gap=%0d exp=1", i, rx_cyc[i] - rx_cyc[i-1]);
        end
      end
    end
    n_vec++;
    if (stat_chip_cnt !== 16'(exp_chip)) begin
      n_err++; $display("FAIL basic_chip_cnt got=%0d exp=%0d", stat_chip_cnt, exp_chip);
    end
  endtask

  task automatic test_gap();
    logic [6:0] path;
    clear_q();
    path = 7'($urandom);
    gen_samples(4);
    model_frame(path);
    push_chip(path, 1'b0);
    for (int i = 1; i <= GT; i++) begin
      step();
      n_vec++;
      if (bif.buf_rdy !== (i < GT)) begin
        n_err++; $display("FAIL gap_buf_rdy idle=%0d got=%b exp=%b", i, bif.buf_rdy, (i < GT));
      end
    end
    wait_rx(exp_q.size());
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL gap_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [17:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL gap_word[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_rdy_random();
    logic [6:0] path;
    clear_q();
    hold_viol = 0;
    bif.tx_rdy = 1'b0;
    path = 7'($urandom);
    gen_samples(CL);
    model_frame(path);
    push_chip(path, 1'b0);
    repeat (20) step();
    n_vec++;
    if (bif.tx_vld !== 1'b1 || bif.tx_data !== SY || bif.tx_sof !== 1'b1 || rx_q.size() != 0) begin
      n_err++; $display("FAIL stall_frozen vld=%b data=%h sof=%b words=%0d exp vld=1 data=%h sof=1 words=0",
                        bif.tx_vld, bif.tx_data, bif.tx_sof, rx_q.size(), SY);
    end
    for (int k = 0; k < 600 && rx_q.size() < exp_q.size(); k++) begin
      bif.tx_rdy = 1'($urandom_range(0, 1));
      step();
    end
    bif.tx_rdy = 1'b1;
    repeat (5) step();
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [17:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL rand_word[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
    n_vec++;
    if (hold_viol != 0) begin
      n_err++; $display("FAIL rand_hold_stable got=%0d changes exp=0", hold_viol);
    end
    n_vec++;
    if (stat_chip_cnt !== 16'(exp_chip)) begin
      n_err++; $display("FAIL rand_chip_cnt got=%0d exp=%0d", stat_chip_cnt, exp_chip);
    end
  endtask

  task automatic test_drop();
    logic [6:0] path;
    clear_q();
    bif.tx_rdy = 1'b1;
    path = 7'($urandom);
    gen_samples(CL);
    model_frame(path);
    push_chip(path, 1'b0);
    for (int i = 0; i < 12; i++) begin
      bif.d1_vld  = 1'b1;
      bif.d1_data = 16'($urandom);
      n_vec++;
      if (bif.buf_rdy !== 1'b0) begin
        n_err++; $display("FAIL drop_buf_rdy[%0d] got=%b exp=0", i, bif.buf_rdy);
      end
      step();
      exp_drop++;
    end
    bif.d1_vld = 1'b0;
    wait_rx(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [17:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL drop_word[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
    n_vec++;
    if (stat_drop_cnt !== 16'(exp_drop)) begin
      n_err++; $display("FAIL drop_cnt got=%0d exp=%0d", stat_drop_cnt, exp_drop);
    end
    clear_q();
    path = 7'($urandom);
    gen_samples(6);
    model_frame(path);
    push_chip(path, 1'b0);
    wait_rx(exp_q.size() + GT);
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL drop_next_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [17:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL drop_next_word[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] path;
    clear_q();
    bif.tx_rdy = 1'b1;
    gen_samples(CL);
    model_frame(7'($urandom));
    push_chip(7'd9, 1'b0);
    for (int k = 0; k < 100 && rx_q.size() < 8; k++) step();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bif.buf_rdy, bif.tx_vld, bif.tx_sof, bif.tx_eof} !== 4'b1000) begin
      n_err++; $display("FAIL midrst_flags got=%b exp=1000", {bif.buf_rdy, bif.tx_vld, bif.tx_sof, bif.tx_eof});
    end
    n_vec++;
    if ({bif.tx_data, stat_chip_cnt, stat_drop_cnt} !== 48'h0) begin
      n_err++; $display("FAIL midrst_values got=%h exp=0", {bif.tx_data, stat_chip_cnt, stat_drop_cnt});
    end
    step();
    rst = 1'b0;
    clear_q();
    exp_chip = 0;
    exp_drop = 0;
    step();
    path = 7'($urandom);
    gen_samples(CL);
    model_frame(path);
    push_chip(path, 1'b0);
    wait_rx(exp_q.size());
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL midrst_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [17:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL midrst_word[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
    n_vec++;
    if (stat_chip_cnt !== 16'(exp_chip)) begin
      n_err++; $display("FAIL midrst_chip_cnt got=%0d exp=%0d", stat_chip_cnt, exp_chip);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gen_samples(CL);
    model_frame(7'd1);
    push_chip(7'd1, 1'b1);
    for (int k = 0; k < 100 && !bif.buf_rdy; k++) step();
    gen_samples(7);
    model_frame(7'd6);
    push_chip(7'd6, 1'b1);
    wait_rx(exp_q.size() + GT);
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [17:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
    n_vec++;
    if (stat_chip_cnt !== 16'(exp_chip)) begin
      n_err++; $display("FAIL b2b_chip_cnt got=%0d exp=%0d", stat_chip_cnt, exp_chip);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_rdy_random();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
